if_prefetch_unit: RTL and testbench
===================================

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of 2, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-005 SHALL have port clk1  in  1  single clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port halted  in  1  when 1, no new fetch requests are issued.
REQ-008 SHALL have ports redirect_valid  in  1  and redirect_pc  in  ADDR_W: taken-branch redirect from EX/MEM.
REQ-009 SHALL have ports imem_req  out  1  and imem_addr  out  ADDR_W: fetch request.
REQ-010 SHALL have port imem_ack  in  1  request accepted.
REQ-011 SHALL have ports imem_rvalid  in  1  and imem_rdata  in  DATA_W: read response.
REQ-012 SHALL have port if_valid  out  1  IF/ID entry available.
REQ-013 SHALL have ports if_ir  out  DATA_W  and if_npc  out  ADDR_W: instruction, and its address plus 1.
REQ-014 SHALL have port if_taken_branch  out  1  entry is the first instruction fetched after a redirect.
REQ-015 SHALL have port id_ready  in  1  decode consumes the head entry.

Function
REQ-016 SHALL use word addressing: next PC = PC+1, wrap-around modulo 2^ADDR_W.
REQ-017 SHALL permit at most one outstanding imem request.
REQ-018 SHALL use FSM states IDLE, REQ (req asserted, awaiting ack), WAIT (acked, awaiting rvalid), DISCARD (awaiting rvalid that must be dropped).
REQ-019 SHALL move IDLE->REQ when !halted and (count + 0) < DEPTH, driving imem_addr=PC.
REQ-020 SHALL keep imem_req and imem_addr stable in REQ until imem_ack; on ack, go REQ->WAIT and set PC<=PC+1.
REQ-021 SHALL, in WAIT on imem_rvalid, push {imem_rdata, addr+1, taken_pending} into the queue, clear taken_pending, and return to IDLE; a new request may issue the next cycle.
REQ-022 SHALL, on redirect_valid, flush the queue (count=0), set PC<=redirect_pc, set taken_pending=1, and discard any push in the same cycle.
REQ-023 SHALL handle redirect by state: in REQ without ack, abandon the request and go to IDLE; in REQ with ack, or in WAIT without rvalid, go to DISCARD; in WAIT with rvalid, drop the data and go to IDLE.
REQ-024 SHALL, in DISCARD on imem_rvalid, drop the data and go to IDLE; a further redirect while in DISCARD only updates PC.
REQ-025 SHALL drive imem_req=1 for the redirect target no earlier than the cycle after redirect_valid.
REQ-026 SHALL drive if_valid = (count != 0), with if_ir, if_npc and if_taken_branch taken from the head entry; data pushed at edge N is visible after edge N.
REQ-027 SHALL pop on if_valid && id_ready && !redirect_valid; simultaneous push and pop keeps count unchanged.
REQ-028 SHALL make overflow impossible by the REQ-019 space check; pop when empty is ignored.
REQ-029 SHALL, while halted, issue no new request, let an outstanding request complete and push, and still honour pops and redirects.

Reset
REQ-030 SHALL, on rst asserted, immediately set PC=RESET_PC, state IDLE, count=0, taken_pending=0, imem_req=0, if_valid=0, and if_taken_branch=0.
REQ-031 SHALL ignore any imem response returned after a mid-operation reset, because the state is IDLE and not WAIT.

Structure
REQ-032 SHALL define the FSM state enum and shared opcode constants (BEQZ, BNEQZ) in package mips_pkg.
REQ-033 SHALL implement the queue as sub-module if_fifo (DEPTH x (DATA_W+ADDR_W+1)), with flush, push and pop ports.

Verification
REQ-034 SHALL cover sequential fetch: RESET_PC=0, ack and rvalid each 1 cycle after request, id_ready=1 -> if_npc sequence 1,2,3,4; all if_taken_branch=0.
REQ-035 SHALL cover backpressure: id_ready=0, DEPTH=4 -> exactly 4 entries queued, imem_req stays 0; one pop -> one new request.
REQ-036 SHALL cover redirect in WAIT: redirect_pc=0x40 while awaiting rvalid -> stale data dropped, next request addr 0x40, first entry npc 0x41 with if_taken_branch=1.
REQ-037 SHALL cover simultaneous redirect and rvalid: rvalid and redirect_pc=0x10 in the same cycle -> queue empty next cycle, next request addr 0x10.
REQ-038 SHALL cover halt: halted=1 with a request outstanding -> one entry pushed, then no imem_req until halted=0.
REQ-039 SHALL cover async reset mid-WAIT: rst pulse, then late rvalid -> if_valid stays 0, next request addr RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end.
package mips_pkg;

  // Fetch FSM states: IDLE (free to issue), REQ (request held until ack),
  // WAIT (acked, awaiting data), DISCARD (acked but redirected, drop data).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  // Conditional-branch opcodes shared with decode/execute.
  localparam logic [5:0] BEQZ  = 6'h04;
  localparam logic [5:0] BNEQZ = 6'h05;

endpackage

// File: rtl/if_fifo.sv
// Prefetch queue: DEPTH entries of WIDTH bits, with flush, push and pop.
// The head entry is presented combinationally from the storage registers.
module if_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 65,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             push_s;
  logic             pop_s;

  // A pop on an empty queue and a push on a full queue are both ignored.
  assign pop_s  = pop && (count_r != {CNT_W{1'b0}});
  assign push_s = push && (count_r != CNT_W'(DEPTH));

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage and pointers; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_nxt_s;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: keeps at most one imem request in flight and
// buffers returned instructions in a small queue feeding the IF/ID stage.
// Taken-branch redirects flush the queue and drop any in-flight response.
module if_prefetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_ir,
  output logic [ADDR_W-1:0] if_npc,
  output logic              if_taken_branch,
  input  logic              id_ready
);

  localparam int ENTRY_W = DATA_W + ADDR_W + 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  fetch_state_e       state_r;
  fetch_state_e       state_nxt_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_seq_s;
  logic [ADDR_W-1:0]  pc_nxt_s;
  logic               taken_pending_r;
  logic               taken_seq_s;
  logic               taken_pending_nxt_s;
  logic               imem_req_r;
  logic               push_s;
  logic               pop_s;
  logic               if_valid_s;
  logic [CNT_W-1:0]   count_s;
  logic [ENTRY_W-1:0] head_s;
  logic [ENTRY_W-1:0] push_data_s;

  // Next-state, PC and push decisions; a redirect overrides PC and marks
  // the next fetched instruction as the branch target.
  always_comb begin
    state_nxt_s = state_r;
    pc_seq_s    = pc_r;
    taken_seq_s = taken_pending_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // Space check against the current occupancy guarantees the queue
        // can never overflow with a single request in flight.
        if (!redirect_valid && !halted && (count_s < CNT_W'(DEPTH))) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (imem_ack) begin
          pc_seq_s = pc_r + ADDR_W'(1'b1);
          if (redirect_valid) begin
            state_nxt_s = DISCARD;
          end else begin
            state_nxt_s = WAIT;
          end
        end else if (redirect_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt_s = IDLE;
          if (!redirect_valid) begin
            push_s      = 1'b1;
            taken_seq_s = 1'b0;
          end else begin
            push_s = 1'b0;
          end
        end else if (redirect_valid) begin
          state_nxt_s = DISCARD;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DISCARD: begin
        if (imem_rvalid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    pc_nxt_s            = redirect_valid ? redirect_pc : pc_seq_s;
    taken_pending_nxt_s = redirect_valid ? 1'b1 : taken_seq_s;
  end

  // FSM state, PC, pending-branch flag and the registered request strobe.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      pc_r            <= RESET_PC;
      taken_pending_r <= 1'b0;
      imem_req_r      <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      pc_r            <= pc_nxt_s;
      taken_pending_r <= taken_pending_nxt_s;
      imem_req_r      <= (state_nxt_s == REQ);
    end
  end

  // PC only advances on ack, so it is stable while the request is held.
  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;

  // In WAIT the PC has already advanced past the fetched word, so it is
  // exactly the address-plus-one carried with the instruction.
  assign push_data_s = {imem_rdata, pc_r, taken_pending_r};
  assign pop_s       = if_valid_s && id_ready && !redirect_valid;

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign if_valid_s      = (count_s != {CNT_W{1'b0}});
  assign if_valid        = if_valid_s;
  assign if_ir           = head_s[ENTRY_W-1 -: DATA_W];
  assign if_npc          = head_s[ADDR_W:1];
  assign if_taken_branch = if_valid_s & head_s[0];

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: a memory responder with
// configurable latency, a stream reference model feeding an expected queue,
// and a monitor that checks every entry consumed by decode.
module tb_if_prefetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        halted;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        if_taken_branch;
  logic        id_ready;

  if_prefetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(RST_PC)
  ) dut (
    .clk1(clk1), .rst(rst), .halted(halted),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc),
    .if_taken_branch(if_taken_branch), .id_ready(id_ready)
  );

  always #5 clk1 = ~clk1;

  int tests = 0;
  int fails = 0;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: consecutive stream per segment -------
  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    logic        taken;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic        model_first;

  function automatic void model_extend(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ir    = mem_word(model_pc);
      e.npc   = model_pc + 32'd1;
      e.taken = model_first;
      exp_q.push_back(e);
      model_pc    = model_pc + 32'd1;
      model_first = 1'b0;
    end
  endfunction

  function automatic void model_restart(input logic [31:0] pc, input logic taken);
    exp_q.delete();
    model_pc    = pc;
    model_first = taken;
    model_extend(32);
  endfunction

  // ---------------- memory responder (drives at negedge + 1) --------------
  logic        mem_fast      = 1'b1;
  logic        hold_rvalid   = 1'b0;
  logic        allow_overlap = 1'b1;
  logic        outstanding   = 1'b0;
  logic [31:0] out_addr      = 32'd0;
  logic [31:0] ack_addr      = 32'd0;
  logic [31:0] last_req_addr = 32'd0;
  int          acks          = 0;
  int          rvalid_cnt    = 0;

  initial begin
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk1); #1;
      if (imem_rvalid) outstanding = 1'b0;
      if (imem_ack) begin
        outstanding = 1'b1;
        out_addr    = ack_addr;
      end
      imem_ack    = 1'b0;
      imem_rvalid = 1'b0;
      if (imem_req && outstanding && !allow_overlap) begin
        tests++;
        fails++;
        $display("FAIL overlap: got second request while one outstanding, addr %0h", imem_addr);
      end
      if (outstanding && !hold_rvalid && (mem_fast || $urandom_range(0, 1) == 1)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(out_addr);
        rvalid_cnt++;
      end else if (!outstanding && imem_req && !rst && (mem_fast || $urandom_range(0, 1) == 1)) begin
        imem_ack      = 1'b1;
        ack_addr      = imem_addr;
        last_req_addr = imem_addr;
        acks++;
      end
    end
  end

  // ---------------- monitor: checks every entry decode consumes -----------
  int          consumed   = 0;
  int          req_cycles = 0;
  logic [31:0] npc_log[$];
  logic        taken_log[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk1);
      if (!rst) begin
        if (imem_req) req_cycles++;
        if (if_valid && id_ready && !redirect_valid) begin
          if (exp_q.size() < 4) model_extend(16);
          e = exp_q.pop_front();
          check("stream_ir", if_ir, e.ir);
          check("stream_npc", if_npc, e.npc);
          check("stream_taken", if_taken_branch, e.taken);
          npc_log.push_back(if_npc);
          taken_log.push_back(if_taken_branch);
          consumed++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk1); #1;
    rst = 1'b1;
    model_restart(RST_PC, 1'b0);
    npc_log.delete();
    taken_log.delete();
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_outstanding(input string name);
    for (int i = 0; i < 100 && !outstanding; i++) step(1);
    check(name, outstanding, 1'b1);
  endtask

  task automatic wait_acks(input string name, input int a0);
    for (int i = 0; i < 100 && acks <= a0; i++) step(1);
    check(name, (acks > a0), 1'b1);
  endtask

  task automatic redirect_once(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    model_restart(pc, 1'b1);
    npc_log.delete();
    taken_log.delete();
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int a0, rq0, rv0, c0;
    rst = 1'b1; halted = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
    model_restart(RST_PC, 1'b0);
    step(2);
    // Reset state
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_taken", if_taken_branch, 1'b0);
    check("rst_imem_addr", imem_addr, RST_PC);
    rst = 1'b0;

    // Sequential fetch: npc 1,2,3,4, none taken
    id_ready = 1'b1; mem_fast = 1'b1;
    c0 = consumed;
    for (int i = 0; i < 100 && consumed - c0 < 4; i++) step(1);
    check("seq_count", (npc_log.size() >= 4), 1'b1);
    if (npc_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("seq_npc", npc_log[i], 32'(i + 1));
        check("seq_taken", taken_log[i], 1'b0);
      end
    end

    // Backpressure: four entries queued, then one pop allows one request
    do_reset();
    id_ready = 1'b0;
    a0 = acks;
    step(40);
    check("bp_acks4", acks - a0, 4);
    rq0 = req_cycles;
    step(10);
    check("bp_no_req", req_cycles - rq0, 0);
    check("bp_valid", if_valid, 1'b1);
    id_ready = 1'b1; step(1); id_ready = 1'b0;
    step(12);
    check("bp_acks5", acks - a0, 5);
    id_ready = 1'b1; step(20);

    // Redirect while awaiting rvalid
    do_reset();
    id_ready = 1'b1; hold_rvalid = 1'b1;
    wait_outstanding("rw_acked");
    redirect_once(32'h40);
    a0 = acks;
    hold_rvalid = 1'b0;
    wait_acks("rw_req", a0);
    check("rw_addr", last_req_addr, 32'h40);
    for (int i = 0; i < 50 && npc_log.size() == 0; i++) step(1);
    check("rw_seen", (npc_log.size() > 0), 1'b1);
    if (npc_log.size() > 0) begin
      check("rw_npc", npc_log[0], 32'h41);
      check("rw_taken", taken_log[0], 1'b1);
    end

    // Redirect and rvalid in the same cycle
    do_reset();
    id_ready = 1'b0;
    step(20);
    hold_rvalid = 1'b1;
    id_ready = 1'b1; step(1); id_ready = 1'b0;
    wait_outstanding("sim_acked");
    check("sim_valid_before", if_valid, 1'b1);
    rv0 = rvalid_cnt;
    hold_rvalid = 1'b0;
    a0 = acks;
    redirect_once(32'h10);
    check("sim_rvalid_same", rvalid_cnt - rv0, 1);
    check("sim_empty", if_valid, 1'b0);
    wait_acks("sim_req", a0);
    check("sim_addr", last_req_addr, 32'h10);
    id_ready = 1'b1; step(20);

    // Halt with a request outstanding
    do_reset();
    id_ready = 1'b0; hold_rvalid = 1'b1;
    wait_outstanding("halt_acked");
    halted = 1'b1;
    rv0 = rvalid_cnt;
    hold_rvalid = 1'b0;
    step(2);
    rq0 = req_cycles; a0 = acks;
    step(20);
    check("halt_rvalid", rvalid_cnt - rv0, 1);
    check("halt_no_ack", acks - a0, 0);
    check("halt_no_req", req_cycles - rq0, 0);
    check("halt_valid", if_valid, 1'b1);
    id_ready = 1'b1; step(1); id_ready = 1'b0;
    step(1);
    check("halt_one_entry", if_valid, 1'b0);
    halted = 1'b0;
    wait_acks("halt_resume", a0);

    // Asynchronous reset while awaiting rvalid, then a late response
    step(10);
    hold_rvalid = 1'b1; id_ready = 1'b1;
    step(10);
    id_ready = 1'b0;
    wait_outstanding("ar_acked");
    rst = 1'b1;
    model_restart(RST_PC, 1'b0);
    npc_log.delete();
    taken_log.delete();
    #1;
    check("ar_req_async", imem_req, 1'b0);
    check("ar_valid_async", if_valid, 1'b0);
    step(1);
    rst = 1'b0;
    rv0 = rvalid_cnt; a0 = acks;
    hold_rvalid = 1'b0;
    for (int i = 0; i < 50 && rvalid_cnt == rv0; i++) step(1);
    check("ar_late_rvalid", rvalid_cnt - rv0, 1);
    check("ar_valid_stays0", if_valid, 1'b0);
    wait_acks("ar_req", a0);
    check("ar_addr", last_req_addr, RST_PC);
    id_ready = 1'b1;
    for (int i = 0; i < 50 && npc_log.size() == 0; i++) step(1);
    check("ar_seen", (npc_log.size() > 0), 1'b1);
    if (npc_log.size() > 0) check("ar_npc", npc_log[0], RST_PC + 32'd1);

    // Random phase: drain, reset quietly, then randomize everything
    halted = 1'b1;
    step(20);
    do_reset();
    step(10);
    halted = 1'b0;
    allow_overlap = 1'b0;
    mem_fast = 1'b0;
    c0 = consumed;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) halted = !halted;
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom);
        model_restart(redirect_pc, 1'b1);
      end else begin
        redirect_valid = 1'b0;
      end
      step(1);
    end
    redirect_valid = 1'b0; halted = 1'b0; id_ready = 1'b1;
    step(40);
    check("rand_progress", (consumed - c0 > 100), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
